reg_dump_scanner: RTL

//   Host-side driver for the CPU debug register port (Reg_Sel -> Reg_Data).
//   On a start pulse it sweeps every GPR index, samples the returned value and

---
 rtl/reg_dump_scanner.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner: sweeps every GPR through the CPU debug register port
// (reg_sel -> reg_data) and streams a framed byte dump over a valid/ready
// byte interface. Frame: SYNC_BYTE, then per register its index byte
// followed by its DATA_W/8 data bytes, MSB first.
module reg_dump_scanner #(
    parameter int          NUM_REGS  = 32,
    parameter int          SEL_W     = 5,
    parameter int          DATA_W    = 32,
    parameter int          SETTLE    = 1,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [SEL_W-1:0]  reg_sel,
    input  logic [DATA_W-1:0] reg_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
    localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(NUM_REGS - 1);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_WAIT,
        ST_SEND_IDX,
        ST_SEND_DAT,
        ST_DONE
    } state_t;

    state_t              r_state,    w_state_nxt;
    logic [SEL_W-1:0]    r_idx,      w_idx_nxt;
    logic [CNT_W-1:0]    r_cnt,      w_cnt_nxt;
    logic [BCNT_W-1:0]   r_bcnt,     w_bcnt_nxt;
    logic [DATA_W-1:0]   r_shift,    w_shift_nxt;
    logic [7:0]          r_tx_data,  w_tx_data_nxt;
    logic                r_tx_valid, w_tx_valid_nxt;
    logic                r_busy,     w_busy_nxt;
    logic                r_done,     w_done_nxt;

    logic                w_xfer;
    logic [DATA_W-1:0]   w_shift_sh;

    assign w_xfer     = r_tx_valid && tx_ready;
    assign w_shift_sh = r_shift << 8;

    // reg_sel is the sweep index itself, so it only moves on WAIT entry
    assign reg_sel  = r_idx;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign done     = r_done;

    // State and registered outputs; synchronous reset aborts any frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_bcnt_nxt     = r_bcnt;
        w_shift_nxt    = r_shift;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt    = ST_SYNC;
                    w_tx_data_nxt  = SYNC_BYTE;
                    w_tx_valid_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                end
            end

            ST_SYNC: begin
                if (w_xfer) begin
                    w_state_nxt    = ST_WAIT;
                    w_tx_valid_nxt = 1'b0;
                    w_idx_nxt      = '0;
                    w_cnt_nxt      = SETTLE_LD;
                end
            end

            ST_WAIT: begin
                // Sample on the last settle cycle so reg_sel has been stable SETTLE cycles
                if (r_cnt == CNT_W'(1)) begin
                    w_shift_nxt    = reg_data;
                    w_state_nxt    = ST_SEND_IDX;
                    w_tx_data_nxt  = 8'(r_idx);
                    w_tx_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end

            ST_SEND_IDX: begin
                if (w_xfer) begin
                    w_state_nxt   = ST_SEND_DAT;
                    w_tx_data_nxt = r_shift[DATA_W-1 -: 8];
                    w_bcnt_nxt    = '0;
                end
            end

            ST_SEND_DAT: begin
                if (w_xfer) begin
                    if (r_bcnt == LAST_BYTE) begin
                        w_tx_valid_nxt = 1'b0;
                        if (r_idx == LAST_IDX) begin
                            w_state_nxt = ST_DONE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_WAIT;
                            w_idx_nxt   = r_idx + SEL_W'(1);
                            w_cnt_nxt   = SETTLE_LD;
                        end
                    end else begin
                        w_shift_nxt   = w_shift_sh;
                        w_tx_data_nxt = w_shift_sh[DATA_W-1 -: 8];
                        w_bcnt_nxt    = r_bcnt + BCNT_W'(1);
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
